// File: rtl/isa_pkg.sv
// Shared ISA definitions for the front end.
//  - Instruction field positions for the opcode and R-type func fields.
//  - Opcode value that marks an R-type instruction.
//  - Fetch-stage state encoding.
package isa_pkg;

  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 27;
  localparam int FUNC_MSB = 6;
  localparam int FUNC_LSB = 2;

  localparam logic [4:0] OPC_RTYPE = 5'b00000;

  typedef enum logic [1:0] {
    FS_BOOT,
    FS_RUN,
    FS_HOLD
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding an instruction word and its PC.
// Catches the word that returns from imem while decode is stalled.
// Ports:
//  clock, reset_n        clock and asynchronous active-low reset
//  load                  capture load_instr/load_pc, mark entry full
//  load_instr, load_pc   word and PC being captured
//  drain                 entry consumed by IF/ID this cycle, mark empty
//  flush                 discard entry (redirect); wins over load/drain
//  full                  entry holds a live word
//  instr, pc             stored word and PC
module fetch_skid #(
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic [31:0]       load_instr,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic              drain,
  input  logic              flush,
  output logic              full,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      full  <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (load) begin
      full  <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC generation, imem read issue, IF/ID register.
// Ports:
//  clock, reset_n        clock and asynchronous active-low reset
//  imem_addr/imem_rd_en  read request to 1-cycle-latency sync imem
//  imem_data             read data, valid the cycle after imem_rd_en
//  stall                 decode cannot accept; IF/ID holds
//  redirect/redirect_pc  flush the pipe and refetch from redirect_pc
//  id_valid, id_instr    IF/ID instruction (instr is 0 when not valid)
//  id_pc, id_pc_plus1    PC of id_instr and PC+1 (wrapping)
//  id_opcode, id_func    decoded fields; func is 0 for non-R-type
module fetch_stage
  import isa_pkg::*;
#(
  parameter int              ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd_en,
  input  logic [31:0]       imem_data,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              id_valid,
  output logic [31:0]       id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] id_pc_plus1,
  output logic [4:0]        id_opcode,
  output logic [4:0]        id_func
);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc_f;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;
  logic              issue;

  logic              skid_load, skid_drain, skid_full;
  logic [31:0]       skid_instr;
  logic [ADDR_W-1:0] skid_pc;

  // Only one word can ever be in flight when a stall begins, because a
  // stalled cycle issues no read; the single skid entry is therefore enough
  // and can never collide with a returning word while draining.
  assign skid_load  = inflight && stall && !redirect;
  assign skid_drain = skid_full && !stall && !redirect;

  fetch_skid #(.ADDR_W(ADDR_W)) u_skid (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (skid_load),
    .load_instr (imem_data),
    .load_pc    (inflight_pc),
    .drain      (skid_drain),
    .flush      (redirect),
    .full       (skid_full),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    imem_rd_en = 1'b0;
    imem_addr  = '0;
    case (state)
      FS_BOOT: state_nxt = FS_RUN;
      FS_RUN:  if (stall && !redirect) state_nxt = FS_HOLD;
      FS_HOLD: if (!stall || redirect) state_nxt = FS_RUN;
      default: state_nxt = FS_BOOT;
    endcase
    // The redirect cycle issues nothing; the target is fetched next cycle.
    if (state != FS_BOOT && !stall && !redirect) begin
      issue      = 1'b1;
      imem_rd_en = 1'b1;
      imem_addr  = pc_f;
    end
  end

  // Fetch stage: PC and in-flight tracking
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FS_BOOT;
      pc_f        <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      state    <= state_nxt;
      // Clearing inflight on redirect kills the word still on its way back.
      inflight <= issue;
      if (issue) inflight_pc <= pc_f;
      if (redirect)   pc_f <= redirect_pc;
      else if (issue) pc_f <= pc_f + 1'b1;
    end
  end

  // IF/ID register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_valid    <= 1'b0;
      id_instr    <= '0;
      id_pc       <= '0;
      id_pc_plus1 <= '0;
    end else if (redirect) begin
      id_valid    <= 1'b0;
      id_instr    <= '0;
      id_pc       <= '0;
      id_pc_plus1 <= '0;
    end else if (!stall) begin
      if (skid_full) begin
        id_valid    <= 1'b1;
        id_instr    <= skid_instr;
        id_pc       <= skid_pc;
        id_pc_plus1 <= skid_pc + 1'b1;
      end else if (inflight) begin
        id_valid    <= 1'b1;
        id_instr    <= imem_data;
        id_pc       <= inflight_pc;
        id_pc_plus1 <= inflight_pc + 1'b1;
      end else begin
        id_valid    <= 1'b0;
        id_instr    <= '0;
        id_pc       <= '0;
        id_pc_plus1 <= '0;
      end
    end
  end

  assign id_opcode = id_instr[OPC_MSB:OPC_LSB];
  assign id_func   = (id_opcode == OPC_RTYPE) ? id_instr[FUNC_MSB:FUNC_LSB] : 5'd0;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [11:0] imem_addr;
  logic        imem_rd_en;
  logic [31:0] imem_data;
  logic        stall, redirect;
  logic [11:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [11:0] id_pc, id_pc_plus1;
  logic [4:0]  id_opcode, id_func;

  // narrow-PC instance used for wrap checks, runs freely from reset
  logic [3:0]  a4_addr;
  logic        a4_rd_en;
  logic [31:0] a4_data;
  logic        a4_stall = 1'b0, a4_redirect = 1'b0;
  logic [3:0]  a4_redirect_pc = 4'd0;
  logic        a4_valid;
  logic [31:0] a4_instr;
  logic [3:0]  a4_pc, a4_pc_plus1;
  logic [4:0]  a4_opcode, a4_func;

  int total  = 0;
  int passed = 0;

  always #5 clock = ~clock;

  fetch_stage #(.ADDR_W(12), .RESET_PC(12'd0)) dut (
    .clock(clock), .reset_n(reset_n),
    .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .imem_data(imem_data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_pc_plus1(id_pc_plus1), .id_opcode(id_opcode), .id_func(id_func)
  );

  fetch_stage #(.ADDR_W(4), .RESET_PC(4'd14)) dut4 (
    .clock(clock), .reset_n(reset_n),
    .imem_addr(a4_addr), .imem_rd_en(a4_rd_en), .imem_data(a4_data),
    .stall(a4_stall), .redirect(a4_redirect), .redirect_pc(a4_redirect_pc),
    .id_valid(a4_valid), .id_instr(a4_instr), .id_pc(a4_pc),
    .id_pc_plus1(a4_pc_plus1), .id_opcode(a4_opcode), .id_func(a4_func)
  );

  // imem contents: word i = i*4, except two hand-placed instructions
  function automatic logic [31:0] mem_word(input logic [11:0] a);
    if (a == 12'h050) return 32'h0000_0004;
    if (a == 12'h051) return 32'h2800_0004;
    return {18'd0, a, 2'b00};
  endfunction

  always @(posedge clock) begin
    if (imem_rd_en) imem_data <= mem_word(imem_addr);
    if (a4_rd_en)   a4_data   <= {26'd0, a4_addr, 2'b00};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc(input logic s, input logic r, input logic [11:0] rpc);
    @(posedge clock);
    #1;
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    #1;
  endtask

  initial begin
    reset_n     = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    #2;
    chk("rst_valid", id_valid, 0);
    chk("rst_rd_en", imem_rd_en, 0);
    chk("rst_instr", id_instr, 0);
    chk("rst_pc_plus1", id_pc_plus1, 0);
    @(posedge clock); @(posedge clock);
    #1 reset_n = 1'b1;
    #1;
    // c0: boot cycle, no read
    chk("c0_rd_en", imem_rd_en, 0);
    cyc(0, 0, 0);  // c1
    chk("c1_rd_en", imem_rd_en, 1);
    chk("c1_addr", imem_addr, 0);
    cyc(0, 0, 0);  // c2
    chk("c2_addr", imem_addr, 1);
    chk("c2_valid", id_valid, 0);
    cyc(0, 0, 0);  // c3
    chk("c3_addr", imem_addr, 2);
    chk("c3_valid", id_valid, 1);
    chk("c3_pc", id_pc, 0);
    chk("c3_plus1", id_pc_plus1, 1);
    chk("w_c3_pc", a4_pc, 14);
    chk("w_c3_plus1", a4_pc_plus1, 15);
    chk("w_c3_instr", a4_instr, 32'h38);
    cyc(0, 0, 0);  // c4
    chk("c4_pc", id_pc, 1);
    chk("c4_instr", id_instr, 4);
    chk("c4_func", id_func, 1);
    chk("w_c4_pc", a4_pc, 15);
    chk("w_c4_plus1", a4_pc_plus1, 0);
    cyc(0, 0, 0);  // c5
    chk("c5_pc", id_pc, 2);
    chk("w_c5_pc", a4_pc, 0);
    chk("w_c5_plus1", a4_pc_plus1, 1);
    cyc(0, 0, 0);  // c6
    chk("c6_pc", id_pc, 3);
    chk("c6_addr", imem_addr, 5);
    // stall three cycles with pc 5 in flight
    cyc(1, 0, 0);  // c7
    chk("c7_pc", id_pc, 4);
    chk("c7_rd_en", imem_rd_en, 0);
    cyc(1, 0, 0);  // c8
    chk("c8_pc", id_pc, 4);
    chk("c8_skid_full", dut.u_skid.full, 1);
    chk("c8_skid_pc", dut.u_skid.pc, 5);
    cyc(1, 0, 0);  // c9
    chk("c9_pc", id_pc, 4);
    chk("c9_valid", id_valid, 1);
    cyc(0, 0, 0);  // c10
    chk("c10_pc", id_pc, 4);
    chk("c10_rd_en", imem_rd_en, 1);
    chk("c10_addr", imem_addr, 6);
    cyc(0, 0, 0);  // c11
    chk("c11_pc", id_pc, 5);
    chk("c11_instr", id_instr, 20);
    cyc(0, 0, 0);  // c12
    chk("c12_pc", id_pc, 6);
    chk("c12_addr", imem_addr, 8);
    // redirect to 0x40 with pc 8 in flight
    cyc(0, 1, 12'h040);  // c13
    chk("c13_pc", id_pc, 7);
    chk("c13_rd_en", imem_rd_en, 0);
    cyc(0, 0, 0);  // c14
    chk("c14_valid", id_valid, 0);
    chk("c14_instr", id_instr, 0);
    chk("c14_addr", imem_addr, 12'h040);
    cyc(0, 0, 0);  // c15
    chk("c15_valid", id_valid, 0);
    cyc(0, 0, 0);  // c16
    chk("c16_valid", id_valid, 1);
    chk("c16_pc", id_pc, 12'h040);
    chk("c16_instr", id_instr, 32'h100);
    // stall fills the skid, then redirect arrives while still stalled
    cyc(1, 0, 0);  // c17
    chk("c17_pc", id_pc, 12'h041);
    cyc(1, 1, 12'h050);  // c18
    chk("c18_rd_en", imem_rd_en, 0);
    cyc(0, 0, 0);  // c19
    chk("c19_valid", id_valid, 0);
    chk("c19_skid_full", dut.u_skid.full, 0);
    chk("c19_rd_en", imem_rd_en, 1);
    chk("c19_addr", imem_addr, 12'h050);
    cyc(0, 0, 0);  // c20
    chk("c20_valid", id_valid, 0);
    cyc(0, 0, 0);  // c21
    chk("c21_pc", id_pc, 12'h050);
    chk("c21_opcode", id_opcode, 0);
    chk("c21_func", id_func, 1);
    cyc(0, 0, 0);  // c22
    chk("c22_pc", id_pc, 12'h051);
    chk("c22_opcode", id_opcode, 5);
    chk("c22_func", id_func, 0);
    // asynchronous reset mid-cycle
    #2 reset_n = 1'b0;
    #1;
    chk("mr_valid", id_valid, 0);
    chk("mr_rd_en", imem_rd_en, 0);
    chk("mr_instr", id_instr, 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    #1;
    chk("mr_c0_rd_en", imem_rd_en, 0);
    cyc(0, 0, 0);
    chk("mr_c1_addr", imem_addr, 0);
    chk("mr_c1_valid", id_valid, 0);
    cyc(0, 0, 0);
    chk("mr_c2_valid", id_valid, 0);
    cyc(0, 0, 0);
    chk("mr_c3_valid", id_valid, 1);
    chk("mr_c3_pc", id_pc, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
